mem_quadrant_reader: RTL and testbench
======================================

MEM_QUADRANT_READER -- requirements
Module: mem_quadrant_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, memory address width.
REQ-002 SHALL have parameter DATA_W, default 19, memory word width.
REQ-003 SHALL have parameter QUAD_WORDS, default 64, words per quadrant (power of two).
REQ-004 SHALL have parameter NUM_QUAD, default 9, number of valid quadrants.
REQ-005 SHALL have port clk, in, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, in, 1, asynchronous, active-low reset.
REQ-007 SHALL have port start, in, 1, one-cycle request to read out a quadrant.
REQ-008 SHALL have port cuadrante, in, 4, quadrant index, sampled when start is accepted.
REQ-009 SHALL have port cant_byte, in, 1, byte mode: 1 emits low 8 bits zero-extended, 0 emits full word; sampled with start.
REQ-010 SHALL have port mem_re, out, 1, read strobe to data memory.
REQ-011 SHALL have port mem_addr, out, ADDR_W, read address.
REQ-012 SHALL have port mem_rdata, in, DATA_W, read data, valid exactly one cycle after mem_re.
REQ-013 SHALL have ports out_data, out, DATA_W, and out_valid, out, 1, output stream.
REQ-014 SHALL have port out_ready, in, 1, sink accepts when out_valid and out_ready are both 1.
REQ-015 SHALL have ports busy, out, 1; done, out, 1 (one-cycle pulse); err, out, 1 (one-cycle pulse).
REQ-016 SHALL have port checksum, out, DATA_W (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE -> READ -> WAIT -> SEND -> (READ or DONE) -> IDLE.
REQ-018 IDLE: start with cuadrante < NUM_QUAD SHALL latch base = cuadrante*QUAD_WORDS, clear the word counter, and go to READ next cycle.
REQ-019 IDLE: start with cuadrante >= NUM_QUAD SHALL pulse err for one cycle, stay IDLE, and issue no memory read.
REQ-020 READ SHALL assert mem_re for exactly one cycle with mem_addr = base + counter.
REQ-021 WAIT SHALL capture mem_rdata into a hold register, masked to [7:0] when byte mode is latched.
REQ-022 SEND SHALL drive out_valid=1 with out_data stable until handshake; out_ready low SHALL stall indefinitely with no new read.
REQ-023 On handshake with counter < QUAD_WORDS-1, SHALL increment counter and go to READ; with counter = QUAD_WORDS-1, SHALL go to DONE.
REQ-024 Address SHALL never exceed base+QUAD_WORDS-1; counter SHALL not wrap within an operation.
REQ-025 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-027 Throughput with out_ready held 1 SHALL be one word per 3 cycles; the first out_valid SHALL come 3 cycles after start.
REQ-028 mem_addr SHALL be 0 whenever mem_re is 0.

Reset
REQ-029 reset low SHALL, asynchronously and at any point including mid-operation, force IDLE, counter 0, and all outputs to 0 (mem_re, mem_addr, out_valid, out_data, busy, done, err, checksum).
REQ-030 After reset release, the first start SHALL begin a fresh operation with no residual state.

Configuration
REQ-031 With READER_CHECKSUM_EN defined, checksum SHALL accumulate the modulo-2^DATA_W sum of every accepted out_data, clear on accepted start, and hold after done.
REQ-032 Without READER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator SHALL exist.

Structure
REQ-033 The FSM state enum, ADDR_W/DATA_W defaults and byte mask SHALL live in the shared package mem_pkg.
REQ-034 The block SHALL be a single module; it SHALL drive the existing Data_Memory read port through a top-level mux with no additional sub-module.

Verification
REQ-035 Preload quadrant 2 (addresses 128..191) with value=address; start, cuadrante=2, cant_byte=0, out_ready=1 -> 64 words 128..191 in order, done 1 cycle after the last handshake.
REQ-036 Same data, cant_byte=1 -> out_data = address & 0xFF, e.g. addr 300 in quadrant 4 -> 0x2C.
REQ-037 start with cuadrante=9 -> err pulse, busy stays 0, mem_re never asserted.
REQ-038 out_ready low for 10 cycles on word 5 -> out_data stable, no mem_re, resumes with word 6 after release.
REQ-039 reset low during word 20 of quadrant 0 -> all outputs 0 immediately; next start on quadrant 1 streams from address 64.
REQ-040 With READER_CHECKSUM_EN, quadrant 0 preloaded with value 1 -> checksum = 64 after done; without the macro -> checksum = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the quadrant reader: memory widths, the byte-mode mask
// and the reader FSM state encoding.
package mem_pkg;

    localparam int MEM_ADDR_W = 19;
    localparam int MEM_DATA_W = 19;

    // Byte mode keeps only the low 8 bits of a memory word.
    localparam logic [7:0] BYTE_MASK = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } rd_state_t;

endpackage

// File: rtl/mem_quadrant_reader.sv
// Streams one quadrant of data memory to a valid/ready sink, one word per three cycles.
// Optional READER_CHECKSUM_EN adds a running sum of every word accepted by the sink.
module mem_quadrant_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int QUAD_WORDS = 64,
    parameter int NUM_QUAD   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cuadrante,
    input  logic              cant_byte,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam int                CNT_W      = $clog2(QUAD_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(QUAD_WORDS - 1);
    localparam logic [4:0]        NUM_QUAD_L = 5'(NUM_QUAD);

    rd_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]  base_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               byte_mode_reg;
    logic [DATA_W-1:0]  hold_reg;
    logic               err_reg;

    logic quad_valid;
    logic accept;
    logic handshake;

    assign quad_valid = ({1'b0, cuadrante} < NUM_QUAD_L);
    assign accept     = (state_reg == ST_IDLE) && start && quad_valid;
    assign handshake  = (state_reg == ST_SEND) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes are decoded from state so that an asynchronous reset clears them at once.
    always_comb begin
        state_next = state_reg;
        mem_re     = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && quad_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                mem_re     = 1'b1;
                mem_addr   = base_reg + ADDR_W'(cnt_reg);
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (cnt_reg == CNT_LAST) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_reg      <= '0;
            cnt_reg       <= '0;
            byte_mode_reg <= 1'b0;
            hold_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= (state_reg == ST_IDLE) && start && !quad_valid;
            if (accept) begin
                base_reg      <= ADDR_W'(cuadrante) << CNT_W;
                cnt_reg       <= '0;
                byte_mode_reg <= cant_byte;
            end
            if (state_reg == ST_WAIT) begin
                hold_reg <= byte_mode_reg ? (mem_rdata & DATA_W'(BYTE_MASK)) : mem_rdata;
            end
            // Counter stops at the last word so the address never leaves the quadrant.
            if (handshake && (cnt_reg != CNT_LAST)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_data = hold_reg;
    assign err      = err_reg;

`ifdef READER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_reg <= '0;
        end else if (accept) begin
            csum_reg <= '0;
        end else if (handshake) begin
            csum_reg <= csum_reg + hold_reg;
        end
    end

    assign checksum = csum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_quadrant_reader.sv
// Directed self-checking bench for mem_quadrant_reader with a one-cycle-latency memory model.
module tb_mem_quadrant_reader;

    localparam int AW = 19;
    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    cuadrante;
    logic          cant_byte;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] exp_sum;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    mem_quadrant_reader #(
        .ADDR_W(AW), .DATA_W(DW), .QUAD_WORDS(64), .NUM_QUAD(9)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cuadrante(cuadrante),
        .cant_byte(cant_byte), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_mem_re"},    32'(mem_re),    0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr),  0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_data"},  32'(out_data),  0);
        check_eq({tag, "_busy"},      32'(busy),      0);
        check_eq({tag, "_done"},      32'(done),      0);
        check_eq({tag, "_err"},       32'(err),       0);
        check_eq({tag, "_checksum"},  32'(checksum),  0);
    endtask

    task automatic check_cksum(input string tag);
`ifdef READER_CHECKSUM_EN
        check_eq(tag, 32'(checksum), 32'(exp_sum));
`else
        check_eq(tag, 32'(checksum), 0);
`endif
    endtask

    // Streams one quadrant; stall_at holds out_ready low on that word, abort_at
    // asserts reset while that word is being offered.
    task automatic run_quad(input int q, input bit bm, input int stall_at, input int abort_at);
        int            base;
        int            reads;
        int            cyc;
        logic [DW-1:0] m;
        logic [DW-1:0] exp_w;
        base      = q * 64;
        reads     = 0;
        exp_sum   = '0;
        cuadrante = 4'(q);
        cant_byte = bm;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 1);
        for (int w = 0; w < 64; w++) begin
            cyc = 0;
            while (!out_valid && cyc < 8) begin
                if (mem_re) begin
                    reads++;
                    check_eq("mem_addr", 32'(mem_addr), 32'(base + w));
                end else begin
                    check_eq("mem_addr_idle", 32'(mem_addr), 0);
                end
                tick();
                cyc++;
            end
            check_eq("latency", 32'(cyc), 2);
            if (!out_valid) return;
            m     = mem[base + w];
            exp_w = bm ? (m & DW'(8'hFF)) : m;
            check_eq("out_data", 32'(out_data), 32'(exp_w));
            if (w == abort_at) begin
                reset = 1'b0;
                #1;
                check_zero("midop_reset");
                $display("quad %0d aborted by reset at word %0d", q, w);
                return;
            end
            if (w == stall_at) begin
                out_ready = 1'b0;
                start     = 1'b1;
                cuadrante = 4'd7;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    start = 1'b0;
                    check_eq("stall_valid", 32'(out_valid), 1);
                    check_eq("stall_data", 32'(out_data), 32'(exp_w));
                    check_eq("stall_mem_re", 32'(mem_re), 0);
                end
                out_ready = 1'b1;
            end
            exp_sum = exp_sum + exp_w;
            tick();
        end
        check_eq("done_pulse", 32'(done), 1);
        check_eq("read_count", 32'(reads), 64);
        check_cksum("checksum_done");
        tick();
        check_eq("done_clear", 32'(done), 0);
        check_eq("busy_idle", 32'(busy), 0);
        check_cksum("checksum_hold");
        $display("quad %0d byte=%0d: %0d reads, checksum=0x%0h", q, bm, reads, checksum);
    endtask

    task automatic err_case(input int q);
        cuadrante = 4'(q);
        cant_byte = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_eq("err_pulse", 32'(err), 1);
        check_eq("err_busy", 32'(busy), 0);
        check_eq("err_mem_re", 32'(mem_re), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("err_clear", 32'(err), 0);
            check_eq("err_busy_after", 32'(busy), 0);
            check_eq("err_mem_re_after", 32'(mem_re), 0);
        end
        $display("quad %0d rejected with err pulse", q);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        cuadrante = 4'd0;
        cant_byte = 1'b0;
        out_ready = 1'b0;
        exp_sum   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);

        repeat (3) tick();
        check_zero("por");
        reset = 1'b1;
        tick();
        check_zero("after_release");

        run_quad(2, 1'b0, -1, -1);
        run_quad(4, 1'b1, -1, -1);
        err_case(9);
        err_case(15);
        run_quad(3, 1'b0, 5, -1);
        run_quad(8, 1'b1, -1, -1);

        run_quad(0, 1'b0, -1, 20);
        repeat (2) tick();
        check_zero("reset_held");
        reset = 1'b1;
        tick();
        check_zero("reset_released");
        run_quad(1, 1'b0, -1, -1);

        for (int i = 0; i < 64; i++) mem[i] = DW'(1);
        run_quad(0, 1'b0, -1, -1);
`ifdef READER_CHECKSUM_EN
        check_eq("checksum_ones", 32'(checksum), 64);
`else
        check_eq("checksum_ones", 32'(checksum), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
